// File: rtl/clkgen_pkg.sv
// Shared clock-generation definitions: supervisor state encoding and counter sizing.
package clkgen_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } clkgen_state_e;

  // Bits needed to hold any value 0..p inclusive.
  function automatic int cnt_w(input int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and downstream-facing signals of the lock supervisor.
interface pll_lock_supervisor_if #(
  parameter int N_DOMAINS = 3
);
  logic                 pll_locked_i;
  logic                 pll_rst_o;
  logic [N_DOMAINS-1:0] domain_rst_o;
  logic                 all_ready_o;
  logic                 fault_o;
  logic [7:0]           retry_count_o;
  logic [7:0]           lock_loss_count_o;

  modport master (
    input  pll_locked_i,
    output pll_rst_o, domain_rst_o, all_ready_o, fault_o, retry_count_o, lock_loss_count_o
  );

  modport slave (
    output pll_locked_i,
    input  pll_rst_o, domain_rst_o, all_ready_o, fault_o, retry_count_o, lock_loss_count_o
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the reference clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // p0: metastability capture; p1: settled value
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, filters lock, releases domain resets staggered,
// retries on timeout and latches a fault after too many failed attempts.
module pll_lock_supervisor
  import clkgen_pkg::*;
#(
  parameter int N_DOMAINS          = 3,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 1048576,
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int RELEASE_STAGGER    = 16,
  parameter int MAX_RETRIES        = 3
) (
  input logic                   clki,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  if (N_DOMAINS < 1)          begin : g_bad_n       $error("N_DOMAINS must be >= 1");          end
  if (PLL_RST_CYCLES < 1)     begin : g_bad_prst    $error("PLL_RST_CYCLES must be >= 1");     end
  if (LOCK_TIMEOUT < 1)       begin : g_bad_tmo     $error("LOCK_TIMEOUT must be >= 1");       end
  if (LOCK_FILTER_CYCLES < 1) begin : g_bad_filt    $error("LOCK_FILTER_CYCLES must be >= 1"); end
  if (RELEASE_STAGGER < 1)    begin : g_bad_stag    $error("RELEASE_STAGGER must be >= 1");    end
  if (MAX_RETRIES < 1)        begin : g_bad_retry   $error("MAX_RETRIES must be >= 1");        end

  localparam int PW = cnt_w(PLL_RST_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int FW = cnt_w(LOCK_FILTER_CYCLES);
  localparam int SW = cnt_w(RELEASE_STAGGER);
  localparam int IW = cnt_w(N_DOMAINS);

  localparam logic [PW-1:0] PLAST = PW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0] FLAST = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [SW-1:0] SLAST = SW'(RELEASE_STAGGER - 1);
  localparam logic [IW-1:0] ILAST = IW'(N_DOMAINS - 1);

  localparam logic [N_DOMAINS-1:0] ALL1 = '1;
  localparam logic [N_DOMAINS-1:0] ONE  = N_DOMAINS'(1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic lock_s;

  sync_2ff u_sync (
    .clk (clki),
    .rst (rst),
    .d   (bus.pll_locked_i),
    .q   (lock_s)
  );

  clkgen_state_e        state;
  logic [PW-1:0]        pcnt;
  logic [TW-1:0]        tcnt;
  logic [FW-1:0]        fcnt;
  logic [SW-1:0]        scnt;
  logic [IW-1:0]        idx;
  logic                 pll_rst;
  logic [N_DOMAINS-1:0] dom_rst;
  logic                 all_ready;
  logic                 fault;
  logic [7:0]           retry_cnt;
  logic [7:0]           loss_cnt;

  logic [7:0] rty_inc;
  logic [7:0] loss_inc;
  logic       rty_hit;

  assign rty_inc  = sat_inc8(retry_cnt);
  assign loss_inc = sat_inc8(loss_cnt);
  assign rty_hit  = (int'(rty_inc) == MAX_RETRIES);

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state     <= PLL_RESET;
      pcnt      <= '0;
      tcnt      <= '0;
      fcnt      <= '0;
      scnt      <= '0;
      idx       <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= ALL1;
      all_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      case (state)
        PLL_RESET: begin
          tcnt <= '0;
          fcnt <= '0;
          if (pcnt == PLAST) begin
            pcnt    <= '0;
            pll_rst <= 1'b0;
            state   <= WAIT_LOCK;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end

        // Timeout outranks both a fresh lock and filter completion.
        WAIT_LOCK, FILTER: begin
          if (tcnt == TLAST) begin
            tcnt      <= '0;
            fcnt      <= '0;
            retry_cnt <= rty_inc;
            pll_rst   <= 1'b1;
            pcnt      <= '0;
            if (rty_hit) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              state <= PLL_RESET;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
            if (!lock_s) begin
              fcnt  <= '0;
              state <= WAIT_LOCK;
            end else if (fcnt == FLAST) begin
              fcnt    <= '0;
              scnt    <= '0;
              idx     <= IW'(1);
              dom_rst <= ALL1 << 1;
              state   <= RELEASE;
              if (N_DOMAINS == 1) begin
                all_ready <= 1'b1;
                retry_cnt <= '0;
              end
            end else begin
              fcnt  <= fcnt + FW'(1);
              state <= FILTER;
            end
          end
        end

        // Lock loss outranks stagger progress; all domains re-enter reset together.
        RELEASE, RUN: begin
          if (!lock_s) begin
            dom_rst   <= ALL1;
            all_ready <= 1'b0;
            loss_cnt  <= loss_inc;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            pcnt      <= '0;
            state     <= PLL_RESET;
          end else if (state == RELEASE) begin
            if (all_ready) begin
              state <= RUN;
            end else if (scnt == SLAST) begin
              scnt    <= '0;
              dom_rst <= dom_rst & ~(ONE << idx);
              idx     <= idx + IW'(1);
              if (idx == ILAST) begin
                all_ready <= 1'b1;
                retry_cnt <= '0;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end

        FAULT: begin
          pll_rst <= 1'b1;
          dom_rst <= ALL1;
          fault   <= 1'b1;
        end

        default: begin
          pll_rst <= 1'b1;
          dom_rst <= ALL1;
          pcnt    <= '0;
          state   <= PLL_RESET;
        end
      endcase
    end
  end

  assign bus.pll_rst_o         = pll_rst;
  assign bus.domain_rst_o      = dom_rst;
  assign bus.all_ready_o       = all_ready;
  assign bus.fault_o           = fault;
  assign bus.retry_count_o     = retry_cnt;
  assign bus.lock_loss_count_o = loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle lock waveforms with checkpoint tables,
// plus hand-written async-reset and loss-counter saturation sequences.
module tb_pll_lock_supervisor;

  localparam int N = 3;

  logic clki = 1'b0;
  logic rst  = 1'b1;

  always #5 clki = ~clki;

  pll_lock_supervisor_if #(.N_DOMAINS(N)) bus ();

  pll_lock_supervisor #(
    .N_DOMAINS          (N),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (64),
    .LOCK_FILTER_CYCLES (8),
    .RELEASE_STAGGER    (4),
    .MAX_RETRIES        (2)
  ) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic       prst;
    logic [2:0] dom;
    logic       rdy;
    logic       flt;
    logic [7:0] rty;
    logic [7:0] loss;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  exp;
    string name;
  } vec_t;

  vec_t  tbl[$];
  logic  wave [0:399];
  string scn;
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.prst = bus.pll_rst_o;
    o.dom  = bus.domain_rst_o;
    o.rdy  = bus.all_ready_o;
    o.flt  = bus.fault_o;
    o.rty  = bus.retry_count_o;
    o.loss = bus.lock_loss_count_o;
    return o;
  endfunction

  function automatic obs_t mk(logic prst, logic [2:0] dom, logic rdy, logic flt, int rty, int loss);
    obs_t o;
    o.prst = prst;
    o.dom  = dom;
    o.rdy  = rdy;
    o.flt  = flt;
    o.rty  = 8'(rty);
    o.loss = 8'(loss);
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got prst=%b dom=%b rdy=%b flt=%b rty=%0d loss=%0d, expected prst=%b dom=%b rdy=%b flt=%b rty=%0d loss=%0d",
               name, act.prst, act.dom, act.rdy, act.flt, act.rty, act.loss,
               exp.prst, exp.dom, exp.rdy, exp.flt, exp.rty, exp.loss);
    end
  endtask

  task automatic add(input int cyc, input logic prst, input logic [2:0] dom, input logic rdy,
                     input logic flt, input int rty, input int loss);
    vec_t v;
    v.cyc  = cyc;
    v.exp  = mk(prst, dom, rdy, flt, rty, loss);
    v.name = $sformatf("%s_c%0d", scn, cyc);
    tbl.push_back(v);
  endtask

  task automatic set_wave(input int a, input int b, input logic v);
    for (int i = a; i <= b; i++) wave[i] = v;
  endtask

  // Leaves the bench in cycle 0: rst just released, first active edge still ahead.
  task automatic do_reset(input string name);
    scn = name;
    tbl.delete();
    for (int i = 0; i < 400; i++) wave[i] = 1'b0;
    bus.pll_locked_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clki);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      bus.pll_locked_i = wave[c];
      foreach (tbl[k]) if (tbl[k].cyc == c) check(tbl[k].name, tbl[k].exp);
      @(negedge clki);
    end
  endtask

  initial begin
    bus.pll_locked_i = 1'b0;

    // Clean acquisition: lock from cycle 6, synced at 8, filter done -> release at 16.
    do_reset("s1");
    set_wave(6, 399, 1'b1);
    add(0,  1, 3'b111, 0, 0, 0, 0);
    add(3,  1, 3'b111, 0, 0, 0, 0);
    add(4,  0, 3'b111, 0, 0, 0, 0);
    add(15, 0, 3'b111, 0, 0, 0, 0);
    add(16, 0, 3'b110, 0, 0, 0, 0);
    add(19, 0, 3'b110, 0, 0, 0, 0);
    add(20, 0, 3'b100, 0, 0, 0, 0);
    add(23, 0, 3'b100, 0, 0, 0, 0);
    add(24, 0, 3'b000, 1, 0, 0, 0);
    add(35, 0, 3'b000, 1, 0, 0, 0);
    run(40);

    // One-cycle glitch during filtering restarts the filter without a PLL reset.
    do_reset("s2");
    set_wave(6, 10, 1'b1);
    set_wave(12, 399, 1'b1);
    add(13, 0, 3'b111, 0, 0, 0, 0);
    add(14, 0, 3'b111, 0, 0, 0, 0);
    add(21, 0, 3'b111, 0, 0, 0, 0);
    add(22, 0, 3'b110, 0, 0, 0, 0);
    add(25, 0, 3'b110, 0, 0, 0, 0);
    add(26, 0, 3'b100, 0, 0, 0, 0);
    add(29, 0, 3'b100, 0, 0, 0, 0);
    add(30, 0, 3'b000, 1, 0, 0, 0);
    run(35);

    // Never locks: two timed-out attempts, then sticky fault ignoring a later lock.
    do_reset("s3");
    set_wave(140, 399, 1'b1);
    add(4,   0, 3'b111, 0, 0, 0, 0);
    add(67,  0, 3'b111, 0, 0, 0, 0);
    add(68,  1, 3'b111, 0, 0, 1, 0);
    add(71,  1, 3'b111, 0, 0, 1, 0);
    add(72,  0, 3'b111, 0, 0, 1, 0);
    add(135, 0, 3'b111, 0, 0, 1, 0);
    add(136, 1, 3'b111, 0, 1, 2, 0);
    add(200, 1, 3'b111, 0, 1, 2, 0);
    add(336, 1, 3'b111, 0, 1, 2, 0);
    run(340);

    // Lock drop in RUN: full re-assert, loss counted, PLL pulsed, then full re-release.
    do_reset("s4");
    set_wave(6, 39, 1'b1);
    set_wave(41, 399, 1'b1);
    add(0,  1, 3'b111, 0, 0, 0, 0);
    add(42, 0, 3'b000, 1, 0, 0, 0);
    add(43, 1, 3'b111, 0, 0, 0, 1);
    add(46, 1, 3'b111, 0, 0, 0, 1);
    add(47, 0, 3'b111, 0, 0, 0, 1);
    add(54, 0, 3'b111, 0, 0, 0, 1);
    add(55, 0, 3'b110, 0, 0, 0, 1);
    add(59, 0, 3'b100, 0, 0, 0, 1);
    add(63, 0, 3'b000, 1, 0, 0, 1);
    run(70);

    // Lock drop between bit0 and bit1 release: all bits re-assert together.
    do_reset("s5");
    set_wave(6, 15, 1'b1);
    set_wave(17, 399, 1'b1);
    add(18, 0, 3'b110, 0, 0, 0, 0);
    add(19, 1, 3'b111, 0, 0, 0, 1);
    add(22, 1, 3'b111, 0, 0, 0, 1);
    add(23, 0, 3'b111, 0, 0, 0, 1);
    add(30, 0, 3'b111, 0, 0, 0, 1);
    add(31, 0, 3'b110, 0, 0, 0, 1);
    add(35, 0, 3'b100, 0, 0, 0, 1);
    add(39, 0, 3'b000, 1, 0, 0, 1);
    run(45);

    // Async reset mid-RELEASE (after one loss) returns outputs to reset values without a clock edge.
    do_reset("s6");
    set_wave(6, 39, 1'b1);
    set_wave(41, 399, 1'b1);
    add(56, 0, 3'b110, 0, 0, 0, 1);
    run(57);
    #2 rst = 1'b1;
    #1 check("s6_async_rst", mk(1, 3'b111, 0, 0, 0, 0));
    @(negedge clki);

    // 300 lock losses: the loss counter saturates at 255.
    do_reset("sat");
    bus.pll_locked_i = 1'b1;
    repeat (40) @(negedge clki);
    for (int j = 0; j < 300; j++) begin
      if (j == 0)   check("sat_start", mk(0, 3'b000, 1, 0, 0, 0));
      if (j == 100) check("sat_100",   mk(0, 3'b000, 1, 0, 0, 100));
      bus.pll_locked_i = 1'b0;
      repeat (2) @(negedge clki);
      bus.pll_locked_i = 1'b1;
      repeat (28) @(negedge clki);
    end
    check("sat_255", mk(0, 3'b000, 1, 0, 0, 255));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
